// File: rtl/trace_pkg.sv
// trace_pkg: state encoding and width helpers shared by the trace collector files.
package trace_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int entry_w(input int nsrc, input int trace_w);
    return log2(nsrc) + trace_w;
  endfunction
endpackage

// File: rtl/trace_collector_if.sv
// trace_collector_if: source, control and readout bundle of the trace collector.
interface trace_collector_if #(
  parameter int NSRC = 5,
  parameter int TRACE_W = 32,
  parameter int TB_DEPTH = 512
);
  import trace_pkg::*;
  localparam int TBW = log2(TB_DEPTH);
  localparam int EW = entry_w(NSRC, TRACE_W);
  logic [NSRC-1:0] src_valid;
  logic [NSRC*TRACE_W-1:0] src_data;
  logic arm;
  logic stop;
  logic [TBW-1:0] post_cnt;
  logic rd;
  logic [EW-1:0] dout;
  logic dout_valid;
  logic [1:0] state;
  logic [TBW:0] entries;
  logic [NSRC-1:0] overflow;
  logic [15:0] drop_cnt;
  modport master (
    output src_valid, src_data, arm, stop, post_cnt, rd,
    input dout, dout_valid, state, entries, overflow, drop_cnt
  );
  modport slave (
    input src_valid, src_data, arm, stop, post_cnt, rd,
    output dout, dout_valid, state, entries, overflow, drop_cnt
  );
endinterface

// File: rtl/trace_src_fifo.sv
// trace_src_fifo: per-source event FIFO; full/empty come from the registered count only,
// so a pop in the same cycle never makes room for a push.
module trace_src_fifo
  import trace_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = log2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_dout = r_mem[r_rd];
  always_ff @(posedge clk)
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/trace_collector.sv
// trace_collector: per-source FIFOs drained round-robin into a circular trace memory
// with arm/stop/post-trigger capture and in-order readout once capture is done.
module trace_collector
  import trace_pkg::*;
#(
  parameter int NSRC = 5,
  parameter int TRACE_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TB_DEPTH = 512
) (
  input logic clk,
  input logic reset,
  trace_collector_if.slave bus
);
  localparam int IDW = log2(NSRC);
  localparam int TBW = log2(TB_DEPTH);
  localparam int EW = entry_w(NSRC, TRACE_W);
  state_t r_state, w_next;
  logic [NSRC-1:0] w_push, w_pop, w_full, w_empty, w_drop, r_overflow;
  logic [TRACE_W-1:0] w_fdata [NSRC];
  logic [IDW-1:0] r_last, w_gnt, w_idx;
  logic w_gnt_vld, w_cap, w_wr, w_rd, r_dout_valid;
  logic [TBW-1:0] r_wr_ptr, r_rd_ptr, r_remaining;
  logic [TBW:0] r_entries;
  logic [15:0] r_drop_cnt;
  logic [16:0] w_drop_sum;
  logic [EW-1:0] r_mem [TB_DEPTH];
  logic [EW-1:0] r_dout;
  assign w_cap = !bus.arm && (r_state == S_ARMED || r_state == S_POST);
  assign w_push = w_cap ? bus.src_valid : '0;
  assign w_drop = w_push & w_full;
  assign w_wr = w_cap && w_gnt_vld;
  assign w_rd = !bus.arm && r_state == S_DONE && bus.rd && r_entries != '0;
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'($countones(w_drop));
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign w_pop[i] = w_wr && w_gnt == IDW'(i);
    trace_src_fifo #(.W(TRACE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .i_flush(bus.arm),
      .i_push(w_push[i]),
      .i_pop(w_pop[i]),
      .i_din(bus.src_data[i*TRACE_W +: TRACE_W]),
      .o_dout(w_fdata[i]),
      .o_full(w_full[i]),
      .o_empty(w_empty[i])
    );
  end
  // scan downward so the source closest after the last grant is the one kept
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = NSRC; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last) + k) % NSRC);
      if (!w_empty[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (bus.arm) w_next = S_ARMED;
    else if (r_state == S_ARMED && bus.stop) w_next = (bus.post_cnt == '0) ? S_DONE : S_POST;
    else if (r_state == S_POST && w_wr && r_remaining == TBW'(1)) w_next = S_DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= {w_gnt, w_fdata[w_gnt]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_entries <= '0;
      r_overflow <= '0;
      r_drop_cnt <= '0;
      r_last <= IDW'(NSRC - 1);
      r_remaining <= '0;
      r_dout <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd;
      if (w_rd) r_dout <= r_mem[r_rd_ptr];
      if (bus.arm) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_entries <= '0;
        r_overflow <= '0;
        r_drop_cnt <= '0;
        r_last <= IDW'(NSRC - 1);
      end else begin
        r_overflow <= r_overflow | w_drop;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_last <= w_gnt;
          if (r_entries == (TBW+1)'(TB_DEPTH)) r_rd_ptr <= r_rd_ptr + 1'b1;
          else r_entries <= r_entries + 1'b1;
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_entries <= r_entries - 1'b1;
        end
        if (r_state == S_ARMED && bus.stop) r_remaining <= bus.post_cnt;
        else if (r_state == S_POST && w_wr) r_remaining <= r_remaining - 1'b1;
      end
    end
  end
  assign bus.dout = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.state = r_state;
  assign bus.entries = r_entries;
  assign bus.overflow = r_overflow;
  assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_trace_collector.sv
// tb_trace_collector: randomized scenarios checked against a queue-based model of the collector.
module tb_trace_collector;
  import trace_pkg::*;
  localparam int NSRC = 5, TW = 32, FD = 4, TBD = 8;
  localparam int IDW = log2(NSRC), TBW = log2(TBD), EW = IDW + TW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  trace_collector_if #(.NSRC(NSRC), .TRACE_W(TW), .TB_DEPTH(TBD)) bus ();
  trace_collector #(.NSRC(NSRC), .TRACE_W(TW), .FIFO_DEPTH(FD), .TB_DEPTH(TBD)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  logic [TW-1:0] q_fifo [NSRC][$];
  logic [EW-1:0] q_mem [$];
  int m_state, m_last, m_rem, m_drops, m_writes;
  logic [NSRC-1:0] m_ov;
  logic [EW-1:0] m_dout;
  logic m_dv;

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) q_fifo[i].delete();
    q_mem.delete();
    m_state = 0; m_last = NSRC - 1; m_rem = 0; m_drops = 0; m_writes = 0;
    m_ov = '0; m_dout = '0; m_dv = 1'b0;
  endtask

  // one clock of the collector, expressed as queue operations
  task automatic model_step();
    int g;
    m_dv = 1'b0;
    if (bus.arm) begin
      for (int i = 0; i < NSRC; i++) q_fifo[i].delete();
      q_mem.delete();
      m_ov = '0; m_drops = 0; m_writes = 0; m_last = NSRC - 1; m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      g = -1;
      for (int k = 1; k <= NSRC; k++)
        if (g < 0 && q_fifo[(m_last + k) % NSRC].size() > 0) g = (m_last + k) % NSRC;
      for (int i = 0; i < NSRC; i++)
        if (bus.src_valid[i]) begin
          if (q_fifo[i].size() >= FD) begin
            m_ov[i] = 1'b1;
            m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
          end else q_fifo[i].push_back(bus.src_data[i*TW +: TW]);
        end
      if (g >= 0) begin
        q_mem.push_back({IDW'(g), q_fifo[g].pop_front()});
        if (q_mem.size() > TBD) void'(q_mem.pop_front());
        m_last = g;
        m_writes++;
        if (m_state == 2) m_rem--;
      end
      if (m_state == 1 && bus.stop) begin
        m_rem = int'(bus.post_cnt);
        m_state = (m_rem == 0) ? 3 : 2;
      end else if (m_state == 2 && m_rem == 0) m_state = 3;
    end else if (m_state == 3 && bus.rd && q_mem.size() > 0) begin
      m_dout = q_mem.pop_front();
      m_dv = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.src_valid = '0; bus.src_data = '0; bus.arm = 1'b0; bus.stop = 1'b0; bus.post_cnt = '0; bus.rd = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
  endtask

  task automatic do_stop(input int post);
    bus.stop = 1'b1; bus.post_cnt = TBW'(post); step(); bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({bus.state, bus.entries, bus.dout_valid, bus.dout, bus.overflow, bus.drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values got st=%0d ent=%0d dv=%b dout=%h ov=%b drop=%0d required all zero",
               bus.state, bus.entries, bus.dout_valid, bus.dout, bus.overflow, bus.drop_cnt);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.state !== 2'd0) begin errors++; $display("FAIL idle_after_reset got %0d required 0", bus.state); end
  endtask

  task automatic test_simultaneous();
    do_arm();
    checks++;
    if (bus.state !== 2'd1) begin errors++; $display("FAIL sim_armed got %0d required 1", bus.state); end
    bus.src_valid = '1;
    for (int i = 0; i < NSRC; i++) bus.src_data[i*TW +: TW] = TW'(32'h100 + i);
    step();
    bus.src_valid = '0;
    repeat (6) step();
    do_stop(0);
    checks++;
    if (bus.state !== 2'd3 || bus.entries !== (TBW+1)'(5)) begin
      errors++; $display("FAIL sim_done got st=%0d ent=%0d required st=3 ent=5", bus.state, bus.entries);
    end
    checks++;
    if (bus.overflow !== '0 || bus.drop_cnt !== '0) begin
      errors++; $display("FAIL sim_nodrop got ov=%b drop=%0d required 0/0", bus.overflow, bus.drop_cnt);
    end
    for (int i = 0; i < NSRC; i++) begin
      bus.rd = 1'b1; step(); bus.rd = 1'b0;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== {IDW'(i), TW'(32'h100 + i)}) begin
        errors++; $display("FAIL sim_read%0d got dv=%b dout=%h required 1 %h", i, bus.dout_valid, bus.dout, {IDW'(i), TW'(32'h100 + i)});
      end
    end
  endtask

  task automatic test_contention();
    logic [IDW-1:0] prev;
    do_arm();
    for (int c = 0; c < 20; c++) begin
      bus.src_valid = 5'b00011;
      bus.src_data[0 +: TW] = $urandom;
      bus.src_data[TW +: TW] = $urandom;
      step();
    end
    bus.src_valid = '0;
    do_stop(0);
    checks++;
    if (bus.overflow !== 5'b00011) begin errors++; $display("FAIL cont_overflow got %b required 00011", bus.overflow); end
    checks++;
    if (int'(bus.drop_cnt) !== 40 - (m_writes + q_fifo[0].size() + q_fifo[1].size())) begin
      errors++; $display("FAIL cont_drops got %0d required %0d", bus.drop_cnt, 40 - (m_writes + q_fifo[0].size() + q_fifo[1].size()));
    end
    checks++;
    if (bus.entries !== (TBW+1)'(TBD)) begin errors++; $display("FAIL cont_entries got %0d required %0d", bus.entries, TBD); end
    prev = '1;
    for (int i = 0; i < TBD; i++) begin
      bus.rd = 1'b1; step(); bus.rd = 1'b0;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== m_dout || (i > 0 && bus.dout[EW-1 -: IDW] === prev)) begin
        errors++; $display("FAIL cont_read%0d got dv=%b dout=%h required %h, id differing from %0d", i, bus.dout_valid, bus.dout, m_dout, prev);
      end
      prev = bus.dout[EW-1 -: IDW];
    end
  endtask

  task automatic test_wrap();
    do_arm();
    for (int k = 1; k <= 12; k++) begin
      bus.src_valid = 5'b00001; bus.src_data[0 +: TW] = TW'(k); step();
    end
    bus.src_valid = '0;
    do_stop(0);
    checks++;
    if (bus.entries !== (TBW+1)'(8)) begin errors++; $display("FAIL wrap_entries got %0d required 8", bus.entries); end
    for (int k = 5; k <= 12; k++) begin
      bus.rd = 1'b1; step(); bus.rd = 1'b0;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== {IDW'(0), TW'(k)}) begin
        errors++; $display("FAIL wrap_read%0d got dv=%b dout=%h", k, bus.dout_valid, bus.dout);
      end
    end
    bus.rd = 1'b1; step(); bus.rd = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== {IDW'(0), TW'(12)} || bus.entries !== '0) begin
      errors++; $display("FAIL wrap_empty_rd got dv=%b dout=%h ent=%0d required 0 %h 0", bus.dout_valid, bus.dout, bus.entries, {IDW'(0), TW'(12)});
    end
  endtask

  task automatic test_post_trigger();
    logic [TW-1:0] ev [5];
    do_arm();
    do_stop(3);
    checks++;
    if (bus.state !== 2'd2) begin errors++; $display("FAIL post_state got %0d required 2", bus.state); end
    for (int e = 0; e < 5; e++) begin
      ev[e] = $urandom;
      bus.src_valid = 5'b01000; bus.src_data[3*TW +: TW] = ev[e];
      bus.stop = (e == 0); bus.post_cnt = TBW'(7);
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (bus.state !== 2'd3 || bus.entries !== (TBW+1)'(3) || bus.drop_cnt !== '0) begin
      errors++; $display("FAIL post_done got st=%0d ent=%0d drop=%0d required 3 3 0", bus.state, bus.entries, bus.drop_cnt);
    end
    for (int e = 0; e < 3; e++) begin
      bus.rd = 1'b1; step(); bus.rd = 1'b0;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== {IDW'(3), ev[e]}) begin
        errors++; $display("FAIL post_read%0d got dv=%b dout=%h required %h", e, bus.dout_valid, bus.dout, {IDW'(3), ev[e]});
      end
    end
  endtask

  task automatic test_reset_mid_post();
    do_arm();
    do_stop(5);
    bus.src_valid = 5'b00100; bus.src_data = {NSRC{32'hCAFE0000}}; step(); step();
    idle_inputs();
    #2 reset = 1'b0;
    #1 model_reset();
    checks++;
    if ({bus.state, bus.entries, bus.dout_valid, bus.dout, bus.overflow, bus.drop_cnt} !== '0) begin
      errors++; $display("FAIL midpost_reset got st=%0d ent=%0d dv=%b ov=%b drop=%0d required all zero",
                         bus.state, bus.entries, bus.dout_valid, bus.overflow, bus.drop_cnt);
    end
    #3 reset = 1'b1;
    step();
    do_arm();
    checks++;
    if (bus.state !== 2'd1 || bus.entries !== '0) begin
      errors++; $display("FAIL midpost_rearm got st=%0d ent=%0d required 1 0", bus.state, bus.entries);
    end
  endtask

  task automatic test_priority();
    bus.src_valid = 5'b10000; bus.src_data[4*TW +: TW] = $urandom; step();
    bus.src_valid = '0; step(); step();
    bus.rd = 1'b1; step(); bus.rd = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.entries !== (TBW+1)'(1)) begin
      errors++; $display("FAIL prio_rd_armed got dv=%b ent=%0d required 0 1", bus.dout_valid, bus.entries);
    end
    do_stop(0);
    bus.arm = 1'b1; bus.stop = 1'b1; step(); idle_inputs();
    checks++;
    if (bus.state !== 2'd1 || bus.entries !== '0) begin
      errors++; $display("FAIL prio_arm_stop got st=%0d ent=%0d required 1 0", bus.state, bus.entries);
    end
  endtask

  task automatic test_random();
    do_arm();
    for (int c = 0; c < 400; c++) begin
      bus.src_valid = NSRC'($urandom) & NSRC'($urandom);
      for (int i = 0; i < NSRC; i++) bus.src_data[i*TW +: TW] = $urandom;
      bus.stop = ($urandom_range(0, 15) == 0);
      bus.post_cnt = TBW'($urandom_range(0, 7));
      bus.rd = $urandom_range(0, 1) == 1;
      bus.arm = (m_state == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 80) == 0;
      step();
      checks++;
      if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state c%0d got %0d required %0d", c, bus.state, m_state); end
      checks++;
      if (bus.entries !== (TBW+1)'(q_mem.size())) begin errors++; $display("FAIL rnd_entries c%0d got %0d required %0d", c, bus.entries, q_mem.size()); end
      checks++;
      if (bus.overflow !== m_ov || int'(bus.drop_cnt) !== m_drops) begin
        errors++; $display("FAIL rnd_drops c%0d got ov=%b drop=%0d required %b %0d", c, bus.overflow, bus.drop_cnt, m_ov, m_drops);
      end
      checks++;
      if (bus.dout_valid !== m_dv || bus.dout !== m_dout) begin
        errors++; $display("FAIL rnd_dout c%0d got dv=%b dout=%h required %b %h", c, bus.dout_valid, bus.dout, m_dv, m_dout);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_arm();
    bus.src_valid = '1;
    for (int c = 0; c < 16700; c++) begin
      for (int i = 0; i < NSRC; i++) bus.src_data[i*TW +: TW] = $urandom;
      step();
      if (c == 16000) begin
        checks++;
        if (int'(bus.drop_cnt) !== m_drops || m_drops >= 65535) begin
          errors++; $display("FAIL sat_mid got %0d required %0d below 65535", bus.drop_cnt, m_drops);
        end
      end
    end
    idle_inputs();
    checks++;
    if (bus.drop_cnt !== 16'hFFFF || m_drops != 65535) begin
      errors++; $display("FAIL sat_final got %h required ffff (model %0d)", bus.drop_cnt, m_drops);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_contention();
    test_wrap();
    test_post_trigger();
    test_reset_mid_post();
    test_priority();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
